// File: rtl/bpm_adjust_if.sv
// bpm_adjust_if: connects the button debouncers, the tempo register and the beat generator.
//
// Signal protocol. This block has no valid/ready pair. Each button has a one-cycle
// x_pressed pulse, which arrives in the same cycle x_state rises, and an x_state level,
// which stays 1 while the button is held. On the output side, bpm always holds the
// current tempo. bpm_changed is a one-cycle strobe in the first cycle a new bpm value
// is visible. Consumers must not apply backpressure.
//
// Ports of the modports:
//   master : drives up_pressed, up_state, down_pressed, down_state;
//            observes bpm, bpm_changed, dbg_state
//   slave  : the tempo block, which consumes the button signals and drives the outputs
interface bpm_adjust_if #(
  parameter int BPM_W = 9
) ();
  logic             up_pressed;
  logic             up_state;
  logic             down_pressed;
  logic             down_state;
  logic [BPM_W-1:0] bpm;
  logic             bpm_changed;
  logic [2:0]       dbg_state;   // current FSM state, for observation only

  modport master (
    output up_pressed, up_state, down_pressed, down_state,
    input  bpm, bpm_changed, dbg_state
  );

  modport slave (
    input  up_pressed, up_state, down_pressed, down_state,
    output bpm, bpm_changed, dbg_state
  );
endinterface

// File: rtl/bpm_adjust.sv
// bpm_adjust: the metronome tempo register, driven by UP/DOWN buttons.
//
// A press steps the tempo once. Holding a button auto-repeats, first after
// HOLD_CYCLES and then every REPEAT_CYCLES. Pressing both buttons restores
// BPM_DEFAULT and locks out steps until both buttons are released.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : bpm_adjust_if.slave, which carries the button inputs, bpm, bpm_changed
//           and dbg_state
module bpm_adjust #(
  parameter int BPM_W         = 9,
  parameter int BPM_MIN       = 30,
  parameter int BPM_MAX       = 300,
  parameter int BPM_DEFAULT   = 120,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 6_000_000,
  parameter int REPEAT_CYCLES = 1_200_000
) (
  input  logic         clk,
  input  logic         rst_n,
  bpm_adjust_if.slave  bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef logic [BPM_W:0]   ext_t;   // one extra bit so that step arithmetic cannot wrap
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ext_t             MIN_X     = ext_t'(BPM_MIN);
  localparam ext_t             MAX_X     = ext_t'(BPM_MAX);
  localparam ext_t             STEP_X    = ext_t'(STEP);
  localparam logic [BPM_W-1:0] DEF_V     = BPM_W'(BPM_DEFAULT);
  localparam cnt_t             HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
  localparam cnt_t             RPT_LAST  = cnt_t'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD_UP = 3'd1,
    RPT_UP  = 3'd2,
    HOLD_DN = 3'd3,
    RPT_DN  = 3'd4,
    LOCK    = 3'd5
  } state_t;

  state_t           state;
  cnt_t             cnt;
  logic [BPM_W-1:0] bpm_q;
  logic             chg_q;

  // Saturating step candidates, computed from the current registered tempo.
  ext_t             cur_x;
  ext_t             up_sum;
  logic [BPM_W-1:0] up_next;
  logic [BPM_W-1:0] dn_next;
  logic             both;

  assign cur_x   = {1'b0, bpm_q};
  assign up_sum  = cur_x + STEP_X;
  assign up_next = (up_sum > MAX_X) ? MAX_X[BPM_W-1:0] : up_sum[BPM_W-1:0];
  assign dn_next = (cur_x < MIN_X + STEP_X) ? MIN_X[BPM_W-1:0] : bpm_q - STEP_X[BPM_W-1:0];

  // Both buttons active, either by level or by a pulse that arrives this cycle.
  assign both = (bus.up_state | bus.up_pressed) & (bus.down_state | bus.down_pressed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bpm_q <= DEF_V;
      chg_q <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (both) begin
        bpm_q <= DEF_V;
        chg_q <= (bpm_q != DEF_V);
        state <= LOCK;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.up_pressed) begin
              bpm_q <= up_next;
              chg_q <= (up_next != bpm_q);
              state <= HOLD_UP;
              cnt   <= '0;
            end else if (bus.down_pressed) begin
              bpm_q <= dn_next;
              chg_q <= (dn_next != bpm_q);
              state <= HOLD_DN;
              cnt   <= '0;
            end
          end
          HOLD_UP, RPT_UP: begin
            // Release takes priority over a step due in the same cycle.
            if (!bus.up_state) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == ((state == HOLD_UP) ? HOLD_LAST : RPT_LAST)) begin
              bpm_q <= up_next;
              chg_q <= (up_next != bpm_q);
              state <= RPT_UP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
          HOLD_DN, RPT_DN: begin
            if (!bus.down_state) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == ((state == HOLD_DN) ? HOLD_LAST : RPT_LAST)) begin
              bpm_q <= dn_next;
              chg_q <= (dn_next != bpm_q);
              state <= RPT_DN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + cnt_t'(1);
            end
          end
          LOCK: begin
            if (!bus.up_state && !bus.down_state) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.bpm         = bpm_q;
  assign bus.bpm_changed = chg_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_bpm_adjust.sv
// tb_bpm_adjust: a self-checking bench for bpm_adjust with short hold and repeat times.
//
// The reference model works in whole tempo values and in cycle offsets measured
// from the press. A step is due at offset 0, and then at HOLD + k*REPEAT.
module tb_bpm_adjust;
  localparam int BPM_W   = 9;
  localparam int HOLD    = 20;
  localparam int REPEAT  = 5;
  localparam int B_MIN   = 30;
  localparam int B_MAX   = 300;
  localparam int B_DEF   = 120;
  localparam int STEP    = 1;

  logic clk;
  logic rst_n;

  bpm_adjust_if #(.BPM_W(BPM_W)) bus ();

  bpm_adjust #(
    .BPM_W(BPM_W), .BPM_MIN(B_MIN), .BPM_MAX(B_MAX), .BPM_DEFAULT(B_DEF),
    .STEP(STEP), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int m_bpm;                      // model tempo
  logic [BPM_W-1:0] exp_q[$];     // expected tempo after each checked cycle
  logic [2:0] idle_code;

  // Driver tasks.
  task automatic set_in(input bit up_p, input bit up_s, input bit dn_p, input bit dn_s);
    bus.up_pressed   = up_p;
    bus.up_state     = up_s;
    bus.down_pressed = dn_p;
    bus.down_state   = dn_s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_bpm = B_DEF;
  endtask

  // Reference model.
  function automatic int m_step(input int b, input bit up);
    if (up) return (b + STEP > B_MAX) ? B_MAX : b + STEP;
    else    return (b - STEP < B_MIN) ? B_MIN : b - STEP;
  endfunction

  function automatic bit step_due(input int t);
    return (t == 0) || (t >= HOLD && ((t - HOLD) % REPEAT) == 0);
  endfunction

  // Tests.
  task automatic test_reset();
    do_reset();
    idle_code = bus.dbg_state;
    n_cmp++;
    if (bus.bpm !== BPM_W'(B_DEF)) begin
      n_fail++; $display("FAIL reset_bpm: got %0d want %0d", bus.bpm, B_DEF);
    end
    n_cmp++;
    if (bus.bpm_changed !== 1'b0) begin
      n_fail++; $display("FAIL reset_chg: got %b want 0", bus.bpm_changed);
    end
  endtask

  task automatic test_tap();
    do_reset();
    set_in(1, 1, 0, 0); tick();
    m_bpm = m_step(m_bpm, 1'b1);
    n_cmp++;
    if (bus.bpm !== BPM_W'(m_bpm) || bus.bpm_changed !== 1'b1) begin
      n_fail++; $display("FAIL tap_up: got bpm=%0d chg=%b want bpm=%0d chg=1", bus.bpm, bus.bpm_changed, m_bpm);
    end
    set_in(0, 0, 0, 0); tick();
    n_cmp++;
    if (bus.bpm !== BPM_W'(121) || bus.bpm_changed !== 1'b0) begin
      n_fail++; $display("FAIL tap_after: got bpm=%0d chg=%b want bpm=121 chg=0", bus.bpm, bus.bpm_changed);
    end
    n_cmp++;
    if (bus.dbg_state !== idle_code) begin
      n_fail++; $display("FAIL tap_idle: got state=%0d want %0d", bus.dbg_state, idle_code);
    end
  endtask

  task automatic test_hold_up();
    int prev;
    int obs_pulses;
    int exp_pulses;
    do_reset();
    obs_pulses = 0;
    exp_pulses = 0;
    for (int t = 0; t < 60; t++) begin
      set_in(t == 0, 1, 0, 0);
      prev = m_bpm;
      if (step_due(t)) m_bpm = m_step(m_bpm, 1'b1);
      if (m_bpm != prev) exp_pulses++;
      exp_q.push_back(BPM_W'(m_bpm));
      tick();
      obs_pulses += int'(bus.bpm_changed);
      n_cmp++;
      if (bus.bpm !== exp_q.pop_front() || bus.bpm_changed !== (m_bpm != prev)) begin
        n_fail++; $display("FAIL hold_up t=%0d: got bpm=%0d chg=%b want bpm=%0d chg=%b",
                           t, bus.bpm, bus.bpm_changed, m_bpm, m_bpm != prev);
      end
    end
    set_in(0, 0, 0, 0); tick();
    n_cmp++;
    if (bus.bpm !== BPM_W'(129) || bus.bpm_changed !== 1'b0) begin
      n_fail++; $display("FAIL hold_up_final: got bpm=%0d chg=%b want bpm=129 chg=0", bus.bpm, bus.bpm_changed);
    end
    n_cmp++;
    if (obs_pulses != exp_pulses || exp_pulses != 9) begin
      n_fail++; $display("FAIL hold_up_pulses: got %0d want %0d", obs_pulses, 9);
    end
  endtask

  task automatic test_saturation();
    int prev;
    do_reset();
    for (int i = 0; i < 181; i++) begin
      prev = m_bpm;
      set_in(1, 1, 0, 0); tick();
      m_bpm = m_step(m_bpm, 1'b1);
      n_cmp++;
      if (bus.bpm !== BPM_W'(m_bpm) || bus.bpm_changed !== (m_bpm != prev)) begin
        n_fail++; $display("FAIL sat_up tap=%0d: got bpm=%0d chg=%b want bpm=%0d chg=%b",
                           i, bus.bpm, bus.bpm_changed, m_bpm, m_bpm != prev);
      end
      set_in(0, 0, 0, 0); tick();
    end
    n_cmp++;
    if (bus.bpm !== BPM_W'(300)) begin
      n_fail++; $display("FAIL sat_max: got %0d want 300", bus.bpm);
    end
    for (int i = 0; i < 271; i++) begin
      prev = m_bpm;
      set_in(0, 0, 1, 1); tick();
      m_bpm = m_step(m_bpm, 1'b0);
      n_cmp++;
      if (bus.bpm !== BPM_W'(m_bpm) || bus.bpm_changed !== (m_bpm != prev)) begin
        n_fail++; $display("FAIL sat_dn tap=%0d: got bpm=%0d chg=%b want bpm=%0d chg=%b",
                           i, bus.bpm, bus.bpm_changed, m_bpm, m_bpm != prev);
      end
      set_in(0, 0, 0, 0); tick();
    end
    n_cmp++;
    if (bus.bpm !== BPM_W'(30)) begin
      n_fail++; $display("FAIL sat_min: got %0d want 30", bus.bpm);
    end
  endtask

  task automatic test_lock();
    int prev;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      prev = m_bpm;
      if (t < 10) begin
        set_in(t == 0, 0, t == 0, 1);
        set_in(0, 0, t == 0, 1);
        if (step_due(t)) m_bpm = m_step(m_bpm, 1'b0);
      end else if (t == 10) begin
        set_in(1, 1, 0, 1);
        m_bpm = B_DEF;
      end else if (t < 20) begin
        set_in(0, 1, 0, 1);
      end else begin
        set_in(0, 0, 0, 1);      // UP released, DOWN still held: still locked
      end
      tick();
      n_cmp++;
      if (bus.bpm !== BPM_W'(m_bpm) || bus.bpm_changed !== (m_bpm != prev)) begin
        n_fail++; $display("FAIL lock t=%0d: got bpm=%0d chg=%b want bpm=%0d chg=%b",
                           t, bus.bpm, bus.bpm_changed, m_bpm, m_bpm != prev);
      end
      if (t == 25) begin
        n_cmp++;
        if (bus.dbg_state === idle_code) begin
          n_fail++; $display("FAIL lock_state: got idle code %0d want a non-idle state", bus.dbg_state);
        end
      end
    end
    set_in(0, 0, 0, 0); tick();
    set_in(0, 0, 1, 1); tick();
    n_cmp++;
    if (bus.bpm !== BPM_W'(119) || bus.bpm_changed !== 1'b1) begin
      n_fail++; $display("FAIL lock_exit_tap: got bpm=%0d chg=%b want bpm=119 chg=1", bus.bpm, bus.bpm_changed);
    end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_both_press();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 1, 0, 0); tick();
      set_in(0, 0, 0, 0); tick();
    end
    n_cmp++;
    if (bus.bpm !== BPM_W'(135)) begin
      n_fail++; $display("FAIL both_setup: got %0d want 135", bus.bpm);
    end
    set_in(1, 1, 1, 1); tick();
    n_cmp++;
    if (bus.bpm !== BPM_W'(120) || bus.bpm_changed !== 1'b1) begin
      n_fail++; $display("FAIL both_restore: got bpm=%0d chg=%b want bpm=120 chg=1", bus.bpm, bus.bpm_changed);
    end
    for (int t = 0; t < 30; t++) begin
      set_in(0, t < 20, 0, 1);
      tick();
      n_cmp++;
      if (bus.bpm !== BPM_W'(120) || bus.bpm_changed !== 1'b0) begin
        n_fail++; $display("FAIL both_lock t=%0d: got bpm=%0d chg=%b want bpm=120 chg=0", t, bus.bpm, bus.bpm_changed);
      end
    end
    set_in(0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0); tick();
    n_cmp++;
    if (bus.bpm !== BPM_W'(121)) begin
      n_fail++; $display("FAIL both_exit_tap: got %0d want 121", bus.bpm);
    end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int t = 0; t < 22; t++) begin
      set_in(t == 0, 1, 0, 0);
      if (step_due(t)) m_bpm = m_step(m_bpm, 1'b1);
      tick();
    end
    n_cmp++;
    if (bus.bpm !== BPM_W'(m_bpm)) begin
      n_fail++; $display("FAIL rst_mid_pre: got %0d want %0d", bus.bpm, m_bpm);
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.bpm !== BPM_W'(B_DEF) || bus.bpm_changed !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got bpm=%0d chg=%b want bpm=120 chg=0", bus.bpm, bus.bpm_changed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_bpm = B_DEF;
    for (int t = 0; t < 30; t++) begin
      set_in(0, 1, 0, 0);
      tick();
      n_cmp++;
      if (bus.bpm !== BPM_W'(B_DEF) || bus.bpm_changed !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_held t=%0d: got bpm=%0d chg=%b want bpm=120 chg=0", t, bus.bpm, bus.bpm_changed);
      end
    end
    set_in(0, 0, 0, 0); tick();
  endtask

  task automatic test_random();
    int prev;
    int kind;
    int len;
    bit up;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 40));
      up   = (kind == 0) || (kind == 3);
      if (kind == 3) len = 1;
      for (int t = 0; t < len; t++) begin
        prev = m_bpm;
        if (kind == 2) begin
          // both pressed together, then the two levels are held; one may be released early
          set_in(t == 0, 1, t == 0, (t < len / 2) || (t == 0));
          if (t == 0) m_bpm = B_DEF;
        end else begin
          if (up) set_in(t == 0, 1, 0, 0);
          else    set_in(0, 0, t == 0, 1);
          if (step_due(t)) m_bpm = m_step(m_bpm, up);
        end
        exp_q.push_back(BPM_W'(m_bpm));
        tick();
        n_cmp++;
        if (bus.bpm !== exp_q.pop_front() || bus.bpm_changed !== (m_bpm != prev)) begin
          n_fail++; $display("FAIL random it=%0d kind=%0d t=%0d: got bpm=%0d chg=%b want bpm=%0d chg=%b",
                             it, kind, t, bus.bpm, bus.bpm_changed, m_bpm, m_bpm != prev);
        end
      end
      repeat (int'($urandom_range(1, 3))) begin
        set_in(0, 0, 0, 0);
        tick();
        n_cmp++;
        if (bus.bpm !== BPM_W'(m_bpm) || bus.bpm_changed !== 1'b0) begin
          n_fail++; $display("FAIL random_gap it=%0d: got bpm=%0d chg=%b want bpm=%0d chg=0",
                             it, bus.bpm, bus.bpm_changed, m_bpm);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_bpm  = B_DEF;
    rst_n  = 1'b0;
    set_in(0, 0, 0, 0);
    test_reset();
    test_tap();
    test_hold_up();
    test_saturation();
    test_lock();
    test_both_press();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog that keeps the run bounded.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
